// File: rtl/adder_result_collector.sv
// Collects the adder core limb stream into the destination register file
// and reports the normalized precision of each result.
module adder_result_collector #(
    parameter int unsigned g_data_width = 64,
    parameter int unsigned g_addr_width = 9,
    parameter int unsigned g_ctrl_width = 8
) (
    input  logic                    r_clk,
    input  logic                    r_rst,
    input  logic [g_ctrl_width-1:0] pi_ctrl,
    input  logic                    pi_ctrl_valid_n,
    input  logic [g_data_width-1:0] pi_data_lo,
    input  logic [g_data_width-1:0] pi_data_up,
    input  logic                    pi_data_wr_en,
    input  logic                    pi_data_last,
    input  logic [1:0]              pi_data_zero,
    output logic [g_addr_width-1:0] po_mem_addr,
    output logic [g_data_width-1:0] po_mem_data_main,
    output logic                    po_mem_wr_en_main,
    output logic [g_data_width-1:0] po_mem_data_ext,
    output logic                    po_mem_wr_en_ext,
    output logic [g_addr_width:0]   po_size_main,
    output logic [g_addr_width:0]   po_size_ext,
    output logic                    po_done,
    output logic                    po_busy,
    output logic                    po_overflow,
    output logic                    po_protocol_err
);

    localparam int unsigned CNT_W   = g_addr_width + 1;
    localparam int unsigned EXT_BIT = 7;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {g_addr_width{1'b0}}};
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             arm;
    logic             beat;
    logic             wr;
    logic             ext_en;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nz_main;
    logic [CNT_W-1:0] nz_ext;
    logic [CNT_W-1:0] nz_main_nx;
    logic [CNT_W-1:0] nz_ext_nx;
    logic             ctrl_unused;

    // Reserved control bits carry no meaning here.
    assign ctrl_unused = ^pi_ctrl[EXT_BIT-1:0];

    // State register.
    always_ff @(posedge r_clk) begin
        if (r_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state, beat qualification and last-non-zero tracking.
    always_comb begin
        state_nx   = state;
        arm        = 1'b0;
        beat       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!pi_ctrl_valid_n) begin
                    arm      = 1'b1;
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (pi_data_wr_en) begin
                    beat     = 1'b1;
                    state_nx = pi_data_last ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (pi_data_wr_en) begin
                    beat = 1'b1;
                    if (pi_data_last) state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Beats past the memory depth are consumed but never written.
        wr         = beat && (cnt != DEPTH);
        nz_main_nx = (wr && !pi_data_zero[0]) ? cnt + ONE : nz_main;
        nz_ext_nx  = (wr && ext_en && !pi_data_zero[1]) ? cnt + ONE : nz_ext;
    end

    // Write port, counters, size reporting and status flags.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            po_mem_addr       <= '0;
            po_mem_data_main  <= '0;
            po_mem_data_ext   <= '0;
            po_mem_wr_en_main <= 1'b0;
            po_mem_wr_en_ext  <= 1'b0;
            po_size_main      <= '0;
            po_size_ext       <= '0;
            po_done           <= 1'b0;
            po_busy           <= 1'b0;
            po_overflow       <= 1'b0;
            po_protocol_err   <= 1'b0;
            ext_en            <= 1'b0;
            cnt               <= '0;
            nz_main           <= '0;
            nz_ext            <= '0;
        end else begin
            po_mem_wr_en_main <= wr;
            po_mem_wr_en_ext  <= wr && ext_en;
            po_done           <= beat && pi_data_last;
            po_busy           <= (state_nx == S_ARMED) || (state_nx == S_COLLECT);
            if (wr) begin
                po_mem_addr      <= cnt[g_addr_width-1:0];
                po_mem_data_main <= pi_data_lo;
                po_mem_data_ext  <= pi_data_up;
            end
            if (arm) begin
                ext_en       <= pi_ctrl[EXT_BIT];
                cnt          <= '0;
                nz_main      <= '0;
                nz_ext       <= '0;
                po_size_main <= '0;
                po_size_ext  <= '0;
                po_overflow  <= 1'b0;
            end else if (beat) begin
                if (wr) cnt <= cnt + ONE;
                else    po_overflow <= 1'b1;
                nz_main <= nz_main_nx;
                nz_ext  <= nz_ext_nx;
                if (pi_data_last) begin
                    // An all-zero result still occupies one limb.
                    po_size_main <= (nz_main_nx == '0) ? ONE : nz_main_nx;
                    if (ext_en) po_size_ext <= (nz_ext_nx == '0) ? ONE : nz_ext_nx;
                    else        po_size_ext <= '0;
                end
            end
            if ((state == S_IDLE) && pi_data_wr_en) po_protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector with a write/done scoreboard.
module tb_adder_result_collector;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          r_clk;
    logic          r_rst;
    logic [7:0]    pi_ctrl;
    logic          pi_ctrl_valid_n;
    logic [DW-1:0] pi_data_lo;
    logic [DW-1:0] pi_data_up;
    logic          pi_data_wr_en;
    logic          pi_data_last;
    logic [1:0]    pi_data_zero;
    logic [AW-1:0] po_mem_addr;
    logic [DW-1:0] po_mem_data_main;
    logic          po_mem_wr_en_main;
    logic [DW-1:0] po_mem_data_ext;
    logic          po_mem_wr_en_ext;
    logic [AW:0]   po_size_main;
    logic [AW:0]   po_size_ext;
    logic          po_done;
    logic          po_busy;
    logic          po_overflow;
    logic          po_protocol_err;

    adder_result_collector #(
        .g_data_width(DW),
        .g_addr_width(AW),
        .g_ctrl_width(8)
    ) dut (
        .r_clk            (r_clk),
        .r_rst            (r_rst),
        .pi_ctrl          (pi_ctrl),
        .pi_ctrl_valid_n  (pi_ctrl_valid_n),
        .pi_data_lo       (pi_data_lo),
        .pi_data_up       (pi_data_up),
        .pi_data_wr_en    (pi_data_wr_en),
        .pi_data_last     (pi_data_last),
        .pi_data_zero     (pi_data_zero),
        .po_mem_addr      (po_mem_addr),
        .po_mem_data_main (po_mem_data_main),
        .po_mem_wr_en_main(po_mem_wr_en_main),
        .po_mem_data_ext  (po_mem_data_ext),
        .po_mem_wr_en_ext (po_mem_wr_en_ext),
        .po_size_main     (po_size_main),
        .po_size_ext      (po_size_ext),
        .po_done          (po_done),
        .po_busy          (po_busy),
        .po_overflow      (po_overflow),
        .po_protocol_err  (po_protocol_err)
    );

    typedef struct {
        int            addr;
        logic [DW-1:0] m;
        logic [DW-1:0] e;
        logic          ext;
        int            stamp;
    } wr_t;

    typedef struct {
        int sm;
        int se;
        int stamp;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    int    n_vec;
    int    n_err;
    int    cyc;

    // Reference state of the result being collected.
    logic  m_ext;
    int    m_cnt;
    int    m_nzm;
    int    m_nze;

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Cycle counter used to time-stamp expected outputs.
    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge r_clk);
        #1;
    endtask

    task automatic arm(input logic ext);
        pi_ctrl         = {ext, 7'h15};
        pi_ctrl_valid_n = 1'b0;
        m_ext = ext;
        m_cnt = 0;
        m_nzm = 0;
        m_nze = 0;
        cycle();
        pi_ctrl_valid_n = 1'b1;
        pi_ctrl         = '0;
    endtask

    task automatic strobe(input logic [7:0] c);
        pi_ctrl         = c;
        pi_ctrl_valid_n = 1'b0;
        cycle();
        pi_ctrl_valid_n = 1'b1;
        pi_ctrl         = '0;
    endtask

    task automatic beat(input logic [DW-1:0] lo, input logic [DW-1:0] up, input logic last);
        wr_t   w;
        done_t d;
        pi_data_lo    = lo;
        pi_data_up    = up;
        pi_data_zero  = {up == '0, lo == '0};
        pi_data_wr_en = 1'b1;
        pi_data_last  = last;
        if (m_cnt < DEPTH) begin
            w.addr  = m_cnt;
            w.m     = lo;
            w.e     = up;
            w.ext   = m_ext;
            w.stamp = cyc + 1;
            wq.push_back(w);
            if (lo != '0) m_nzm = m_cnt + 1;
            if (up != '0 && m_ext) m_nze = m_cnt + 1;
            m_cnt++;
        end
        if (last) begin
            d.sm    = (m_nzm == 0) ? 1 : m_nzm;
            d.se    = m_ext ? ((m_nze == 0) ? 1 : m_nze) : 0;
            d.stamp = cyc + 1;
            dq.push_back(d);
        end
        cycle();
        pi_data_wr_en = 1'b0;
        pi_data_last  = 1'b0;
    endtask

    // Scoreboard: every write and done pulse must match an expected entry.
    always @(negedge r_clk) begin
        if (po_mem_wr_en_main) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 64'(po_mem_addr), 64'hffff);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(w.stamp));
                chk("wr_addr", 64'(po_mem_addr), 64'(w.addr));
                chk("wr_data_main", po_mem_data_main, w.m);
                chk("wr_en_ext", 64'(po_mem_wr_en_ext), 64'(w.ext));
                if (w.ext) chk("wr_data_ext", po_mem_data_ext, w.e);
            end
        end else if (po_mem_wr_en_ext) begin
            chk("stray_ext_write", 64'(po_mem_wr_en_ext), 64'd0);
        end
        if (po_done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 64'(po_done), 64'd0);
            end else begin
                done_t d;
                d = dq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(d.stamp));
                chk("size_main", 64'(po_size_main), 64'(d.sm));
                chk("size_ext", 64'(po_size_ext), 64'(d.se));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        m_ext = 1'b0;
        m_cnt = 0;
        m_nzm = 0;
        m_nze = 0;
        r_rst           = 1'b1;
        pi_ctrl         = '0;
        pi_ctrl_valid_n = 1'b1;
        pi_data_lo      = '0;
        pi_data_up      = '0;
        pi_data_wr_en   = 1'b0;
        pi_data_last    = 1'b0;
        pi_data_zero    = '0;
        repeat (2) cycle();
        r_rst = 1'b0;
        cycle();
        chk("rst_busy", 64'(po_busy), 64'd0);
        chk("rst_done", 64'(po_done), 64'd0);
        chk("rst_size_main", 64'(po_size_main), 64'd0);
        chk("rst_overflow", 64'(po_overflow), 64'd0);
        chk("rst_perr", 64'(po_protocol_err), 64'd0);

        // Three main-only limbs, trailing limb non-zero.
        arm(1'b0);
        chk("t1_busy_armed", 64'(po_busy), 64'd1);
        beat(64'd5, 64'd11, 1'b0);
        beat(64'd0, 64'd12, 1'b0);
        beat(64'd7, 64'd13, 1'b1);
        chk("t1_busy_done", 64'(po_busy), 64'd0);
        repeat (3) cycle();
        chk("t1_size_hold", 64'(po_size_main), 64'd3);
        chk("t1_size_ext_hold", 64'(po_size_ext), 64'd0);

        // Extended result filling the memory exactly.
        arm(1'b1);
        chk("t2_size_cleared", 64'(po_size_main), 64'd0);
        beat(64'h9, 64'h1, 1'b0);
        beat(64'h0, 64'h2, 1'b0);
        beat(64'h0, 64'h3, 1'b0);
        beat(64'h0, 64'h4, 1'b1);
        cycle();
        chk("t2_no_overflow", 64'(po_overflow), 64'd0);

        // Single all-zero limb.
        arm(1'b0);
        beat(64'd0, 64'd0, 1'b1);
        cycle();

        // Six limbs into a four-deep memory.
        arm(1'b0);
        for (int i = 0; i < 6; i++) beat(64'(i + 100), 64'd0, i == 5);
        cycle();
        chk("t4_overflow", 64'(po_overflow), 64'd1);
        chk("t4_size_sat", 64'(po_size_main), 64'd4);

        // Data while idle is a protocol error and is not written.
        beat_idle();
        cycle();
        chk("t5_perr", 64'(po_protocol_err), 64'd1);

        // Reset in the middle of a result.
        arm(1'b0);
        chk("t5_overflow_cleared", 64'(po_overflow), 64'd0);
        beat(64'd21, 64'd0, 1'b0);
        beat(64'd22, 64'd0, 1'b0);
        cycle();
        r_rst = 1'b1;
        cycle();
        chk("t5_rst_busy", 64'(po_busy), 64'd0);
        chk("t5_rst_perr", 64'(po_protocol_err), 64'd0);
        chk("t5_rst_wr", 64'(po_mem_wr_en_main), 64'd0);
        r_rst = 1'b0;
        cycle();
        arm(1'b1);
        beat(64'd0, 64'd0, 1'b0);
        beat(64'd3, 64'd0, 1'b0);
        beat(64'd0, 64'd0, 1'b1);
        cycle();

        // Gapped beats with arm strobes that must be ignored.
        arm(1'b0);
        beat(64'd1, 64'd5, 1'b0);
        strobe(8'h80);
        cycle();
        beat(64'd2, 64'd6, 1'b0);
        cycle();
        strobe(8'h80);
        beat(64'd0, 64'd7, 1'b1);
        repeat (3) cycle();
        chk("t6_busy", 64'(po_busy), 64'd0);
        chk("t6_size_ext", 64'(po_size_ext), 64'd0);

        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic beat_idle();
        pi_data_lo    = 64'hdead;
        pi_data_up    = 64'hbeef;
        pi_data_zero  = 2'b00;
        pi_data_wr_en = 1'b1;
        cycle();
        pi_data_wr_en = 1'b0;
    endtask

endmodule
